// File: rtl/ofdm_symbol_sequencer.sv
// Per-frame TX sequencer: computes N_SYM from a frame descriptor and frames the coded byte stream
// into one SIGNAL symbol plus N_SYM data symbols. Optional macro SYM_SEQ_TLAST_CHECK_EN adds encoder tlast checking.
module ofdm_symbol_sequencer #(
   parameter int LEN_WIDTH  = 12,
   parameter int NSYM_WIDTH = 11
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [3:0]            cfg_rate,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic                  cfg_tvalid,
   output logic                  cfg_tready,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [7:0]            m_axis_tdata,
   output logic [3:0]            m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [NSYM_WIDTH-1:0] nsym,
   output logic                  busy,
   output logic                  err
);
   localparam int BITS_W = LEN_WIDTH + 4;

   // 802.11a SIGNAL-field RATE codes
   localparam logic [3:0] RATE_6M  = 4'b1011;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b1010;
   localparam logic [3:0] RATE_18M = 4'b1110;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1101;
   localparam logic [3:0] RATE_48M = 4'b1000;
   localparam logic [3:0] RATE_54M = 4'b1100;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_SIGNAL = 2'd2;
   localparam logic [1:0] S_DATA   = 2'd3;

   function automatic logic rate_ok(input logic [3:0] r);
      case (r)
         RATE_6M, RATE_9M, RATE_12M, RATE_18M,
         RATE_24M, RATE_36M, RATE_48M, RATE_54M: rate_ok = 1'b1;
         default:                                rate_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] ndbps_of(input logic [3:0] r);
      case (r)
         RATE_9M:  ndbps_of = 8'd36;
         RATE_12M: ndbps_of = 8'd48;
         RATE_18M: ndbps_of = 8'd72;
         RATE_24M: ndbps_of = 8'd96;
         RATE_36M: ndbps_of = 8'd144;
         RATE_48M: ndbps_of = 8'd192;
         RATE_54M: ndbps_of = 8'd216;
         default:  ndbps_of = 8'd24;
      endcase
   endfunction

   function automatic logic [5:0] sym_bytes_of(input logic [3:0] r);
      case (r)
         RATE_12M, RATE_18M: sym_bytes_of = 6'd12;
         RATE_24M, RATE_36M: sym_bytes_of = 6'd24;
         RATE_48M, RATE_54M: sym_bytes_of = 6'd36;
         default:            sym_bytes_of = 6'd6;
      endcase
   endfunction

   logic [1:0]            state_q, state_d;
   logic [3:0]            rate_q, rate_d;
   logic [BITS_W-1:0]     bits_q, bits_d;
   logic [NSYM_WIDTH-1:0] nsym_q, nsym_d;
   logic [NSYM_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
   logic [5:0]            byte_cnt_q, byte_cnt_d;
   logic                  err_q, err_d;

   logic [7:0] ndbps_cur;
   logic [5:0] sym_bytes_cur;
   logic       passthru, m_hs, cfg_hs, sym_end, frame_last, tlast_err;

   assign ndbps_cur     = ndbps_of(rate_q);
   assign sym_bytes_cur = sym_bytes_of(rate_q);
   assign passthru      = (state_q == S_SIGNAL) || (state_q == S_DATA);
   assign m_hs          = passthru && s_axis_tvalid && m_axis_tready;
   assign cfg_hs        = cfg_tvalid && cfg_tready;
   assign sym_end       = (byte_cnt_q == sym_bytes_cur - 6'd1);
   assign frame_last    = (state_q == S_DATA) && (sym_cnt_q == NSYM_WIDTH'(1)) && sym_end;

   // Zero-latency passthrough: the interleaver sees the encoder directly while a frame is open
   assign cfg_tready    = (state_q == S_IDLE);
   assign s_axis_tready = passthru && m_axis_tready;
   assign m_axis_tvalid = passthru && s_axis_tvalid;
   assign m_axis_tdata  = passthru ? s_axis_tdata : 8'd0;
   assign m_axis_tlast  = frame_last;
   assign m_axis_tuser  = (state_q == S_SIGNAL) ? RATE_6M :
                          (state_q == S_DATA)   ? rate_q  : 4'd0;
   assign nsym          = nsym_q;
   assign busy          = (state_q != S_IDLE);
   assign err           = err_q;

`ifdef SYM_SEQ_TLAST_CHECK_EN
   logic tlast_sticky_q, tlast_sticky_d;
   logic unused_tlast_sticky;
   assign tlast_err           = m_hs && (s_axis_tlast != frame_last);
   assign tlast_sticky_d      = cfg_hs ? 1'b0 : (tlast_sticky_q | tlast_err);
   assign unused_tlast_sticky = tlast_sticky_q;
   always_ff @(posedge aclk) begin
      if (!aresetn) tlast_sticky_q <= 1'b0;
      else          tlast_sticky_q <= tlast_sticky_d;
   end
`else
   logic unused_s_tlast;
   assign tlast_err      = 1'b0;
   assign unused_s_tlast = s_axis_tlast;
`endif

   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      bits_d     = bits_q;
      nsym_d     = nsym_q;
      sym_cnt_d  = sym_cnt_q;
      byte_cnt_d = byte_cnt_q;
      err_d      = tlast_err;
      case (state_q)
         S_IDLE: begin
            if (cfg_hs) begin
               if (rate_ok(cfg_rate)) begin
                  rate_d  = cfg_rate;
                  bits_d  = BITS_W'({cfg_len, 3'b000}) + BITS_W'(22);
                  nsym_d  = '0;
                  state_d = S_CALC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // Repeated subtraction: one N_DBPS per cycle yields the ceiling quotient
         S_CALC: begin
            nsym_d = nsym_q + NSYM_WIDTH'(1);
            if (bits_q <= BITS_W'(ndbps_cur)) begin
               sym_cnt_d  = nsym_q + NSYM_WIDTH'(1);
               byte_cnt_d = '0;
               state_d    = S_SIGNAL;
            end else begin
               bits_d = bits_q - BITS_W'(ndbps_cur);
            end
         end
         S_SIGNAL: begin
            if (m_hs) begin
               if (byte_cnt_q == 6'd5) begin
                  byte_cnt_d = '0;
                  state_d    = S_DATA;
               end else begin
                  byte_cnt_d = byte_cnt_q + 6'd1;
               end
            end
         end
         default: begin
            if (m_hs) begin
               if (sym_end) begin
                  byte_cnt_d = '0;
                  sym_cnt_d  = sym_cnt_q - NSYM_WIDTH'(1);
                  if (sym_cnt_q == NSYM_WIDTH'(1)) state_d = S_IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 6'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         rate_q     <= '0;
         bits_q     <= '0;
         nsym_q     <= '0;
         sym_cnt_q  <= '0;
         byte_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rate_q     <= rate_d;
         bits_q     <= bits_d;
         nsym_q     <= nsym_d;
         sym_cnt_q  <= sym_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// Directed self-checking bench for ofdm_symbol_sequencer: frame lengths, CALC latency, tags, tlast, errors, reset.
module tb_ofdm_symbol_sequencer;
   localparam logic [3:0] RATE_6M  = 4'b1011;
   localparam logic [3:0] RATE_12M = 4'b1010;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1101;
   localparam logic [3:0] RATE_54M = 4'b1100;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  cfg_rate = 4'd0;
   logic [11:0] cfg_len = 12'd0;
   logic        cfg_tvalid = 1'b0;
   logic        cfg_tready;
   logic [7:0]  s_axis_tdata = 8'd0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic [3:0]  m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic [10:0] nsym;
   logic        busy;
   logic        err;

   int checks = 0;
   int failures = 0;

   ofdm_symbol_sequencer #(.LEN_WIDTH(12), .NSYM_WIDTH(11)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cfg_rate(cfg_rate), .cfg_len(cfg_len), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .nsym(nsym), .busy(busy), .err(err)
   );

   always #5 aclk = ~aclk;

   task automatic test_reset();
      aresetn = 1'b0;
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++; if (cfg_tready !== 1'b1) begin failures++; $display("FAIL reset_cfg_tready got=%b exp=1", cfg_tready); end
      checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready got=%b exp=0", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_m_tlast got=%b exp=0", m_axis_tlast); end
      checks++; if (m_axis_tuser !== 4'd0) begin failures++; $display("FAIL reset_m_tuser got=%h exp=0", m_axis_tuser); end
      checks++; if (nsym !== 11'd0) begin failures++; $display("FAIL reset_nsym got=%0d exp=0", nsym); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      @(posedge aclk); #1;
      aresetn = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      $display("reset: done");
   endtask

   // Runs one complete frame; source data is 0x5A + byte index, so drops/duplicates show as data errors.
   task automatic run_frame(input string nm, input logic [3:0] rate, input int len,
                            input int exp_nsym, input int exp_total, input bit rnd);
      int calc, idx, cyc;
      bit done;
      @(posedge aclk); #1;
      cfg_rate = rate;
      cfg_len = 12'(len);
      cfg_tvalid = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'h5A;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      checks++; if (cfg_tready !== 1'b1) begin failures++; $display("FAIL %s cfg_tready_idle got=%b exp=1", nm, cfg_tready); end
      @(posedge aclk); #1;
      cfg_tvalid = 1'b0;
      calc = 0;
      @(negedge aclk);
      while (!m_axis_tvalid && calc < 3000) begin
         calc++;
         @(negedge aclk);
      end
      checks++; if (calc != exp_nsym) begin failures++; $display("FAIL %s calc_latency got=%0d exp=%0d", nm, calc, exp_nsym); end
      checks++; if (nsym !== 11'(exp_nsym)) begin failures++; $display("FAIL %s nsym got=%0d exp=%0d", nm, nsym, exp_nsym); end
      idx = 0; done = 1'b0; cyc = 0;
      while (!done && cyc < 5000) begin
         if (m_axis_tvalid && m_axis_tready) begin
            checks++; if (m_axis_tdata !== 8'(8'h5A + idx)) begin failures++;
               $display("FAIL %s tdata[%0d] got=%h exp=%h", nm, idx, m_axis_tdata, 8'(8'h5A + idx)); end
            checks++; if (m_axis_tuser !== ((idx < 6) ? RATE_6M : rate)) begin failures++;
               $display("FAIL %s tuser[%0d] got=%h exp=%h", nm, idx, m_axis_tuser, (idx < 6) ? RATE_6M : rate); end
            checks++; if (m_axis_tlast !== (idx == exp_total - 1)) begin failures++;
               $display("FAIL %s tlast[%0d] got=%b exp=%b", nm, idx, m_axis_tlast, (idx == exp_total - 1)); end
            checks++; if (s_axis_tready !== 1'b1) begin failures++;
               $display("FAIL %s s_tready[%0d] got=%b exp=1", nm, idx, s_axis_tready); end
            if (m_axis_tlast) done = 1'b1;
            idx++;
         end else if (m_axis_tvalid) begin
            checks++; if (s_axis_tready !== 1'b0) begin failures++;
               $display("FAIL %s s_tready_stall got=%b exp=0", nm, s_axis_tready); end
         end
         if (!done) begin
            @(posedge aclk); #1;
            s_axis_tdata = 8'(8'h5A + idx);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            cyc++;
         end
      end
      checks++; if (!done) begin failures++; $display("FAIL %s tlast_timeout got=none exp=tlast", nm); end
      checks++; if (idx != exp_total) begin failures++; $display("FAIL %s byte_count got=%0d exp=%0d", nm, idx, exp_total); end
      @(posedge aclk); #1;
      checks++; if (cfg_tready !== 1'b1) begin failures++; $display("FAIL %s cfg_tready_after got=%b exp=1", nm, cfg_tready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", nm, busy); end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL %s tvalid_after got=%b exp=0", nm, m_axis_tvalid); end
      checks++; if (nsym !== 11'(exp_nsym)) begin failures++; $display("FAIL %s nsym_hold got=%0d exp=%0d", nm, nsym, exp_nsym); end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      $display("frame %s: rate=%h len=%0d nsym=%0d bytes=%0d calc=%0d", nm, rate, len, nsym, idx, calc);
   endtask

   task automatic test_frames();
      run_frame("54M_len100", RATE_54M, 100, 4, 150, 1'b0);
      run_frame("6M_len0", RATE_6M, 0, 1, 12, 1'b0);
      run_frame("24M_len9", RATE_24M, 9, 1, 30, 1'b0);
      run_frame("24M_len10", RATE_24M, 10, 2, 54, 1'b0);
   endtask

   task automatic test_backpressure();
      run_frame("36M_len200_rnd", RATE_36M, 200, 12, 294, 1'b1);
   endtask

   task automatic test_invalid_rate();
      int errs;
      @(posedge aclk); #1;
      cfg_rate = 4'b0000;
      cfg_len = 12'd10;
      cfg_tvalid = 1'b1;
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      cfg_tvalid = 1'b0;
      errs = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         if (i == 0) begin
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_rate err_first got=%b exp=1", err); end
         end
         if (err === 1'b1) errs++;
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_rate busy got=%b exp=0", busy); end
         checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL bad_rate tvalid got=%b exp=0", m_axis_tvalid); end
      end
      checks++; if (errs != 1) begin failures++; $display("FAIL bad_rate err_cycles got=%0d exp=1", errs); end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      $display("bad_rate: err_cycles=%0d", errs);
   endtask

   task automatic test_reset_mid_frame();
      int hs, cyc;
      @(posedge aclk); #1;
      cfg_rate = RATE_12M;
      cfg_len = 12'd50;
      cfg_tvalid = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 8'h11;
      m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      cfg_tvalid = 1'b0;
      hs = 0; cyc = 0;
      while (hs < 26 && cyc < 200) begin
         @(negedge aclk);
         if (m_axis_tvalid && m_axis_tready) hs++;
         cyc++;
         if (hs < 26) @(posedge aclk);
      end
      checks++; if (hs != 26) begin failures++; $display("FAIL rst_mid reach_byte got=%0d exp=26", hs); end
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_mid tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
      checks++; if (cfg_tready !== 1'b1) begin failures++; $display("FAIL rst_mid cfg_tready got=%b exp=1", cfg_tready); end
      checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_mid tlast got=%b exp=0", m_axis_tlast); end
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      $display("rst_mid: reset after %0d bytes", hs);
      run_frame("6M_len0_after_rst", RATE_6M, 0, 1, 12, 1'b0);
   endtask

   initial begin
      test_reset();
      test_frames();
      test_backpressure();
      test_invalid_rate();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
